// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, registers the ROM word into IR_IF, freezes on hazards
// and squashes the wrong-path slot with a NOP bubble on branch redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'hffff_ffff,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hasHazard,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IR_IF,
  output logic [31:0]      PC_IF,
  output logic             valid_IF,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pcif_q, pcif_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      redirect_pc;
  logic             cnt_sat;

  assign redirect_pc = {branch_target[31:2], 2'b00};
  assign cnt_sat     = (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pcif_d  = pcif_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN, STALL, FLUSH: begin
        if (branch_taken) begin
          // Redirect wins over a hazard; the bubble already sits in IR_IF during FLUSH.
          pc_d    = redirect_pc;
          ir_d    = NOP_WORD;
          pcif_d  = redirect_pc;
          valid_d = 1'b0;
          state_d = FLUSH;
        end else if (hasHazard && (state_q != FLUSH)) begin
          if (!cnt_sat) cnt_d = cnt_q + 1'b1;
          state_d = STALL;
        end else begin
          ir_d    = imem_rdata;
          pcif_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      pcif_q  <= RESET_PC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pcif_q  <= pcif_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign IR_IF     = ir_q;
  assign PC_IF     = pcif_q;
  assign valid_IF  = valid_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for the main pipeline flow, plus hand-written
// sequences for asynchronous reset mid-stall, IDLE behaviour and counter saturation.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hasHazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IR_IF;
  logic [31:0] PC_IF;
  logic        valid_IF;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'hffff_ffff;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .hasHazard     (hasHazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .IR_IF         (IR_IF),
    .PC_IF         (PC_IF),
    .valid_IF      (valid_IF),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h8c01_0014;
      32'h0000_0004: rom = 32'h8c06_0015;
      32'h0000_0008: rom = 32'h0000_1820;
      32'h0000_000c: rom = 32'h8c06_0015;
      default:       rom = 32'ha000_0000 ^ a;
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  typedef struct {
    logic        start;
    logic        hh;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] ir;
    logic [31:0] pcif;
    logic        valid;
    logic [31:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic s, logic h, logic b, logic [31:0] t, logic [31:0] ir,
                              logic [31:0] pcif, logic v, logic [31:0] addr, logic [15:0] cnt);
    vec_t r;
    r.start = s; r.hh = h; r.br = b; r.tgt = t;
    r.ir = ir; r.pcif = pcif; r.valid = v; r.addr = addr; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ir, input logic [31:0] pcif,
                         input logic v, input logic [31:0] addr, input logic [15:0] cnt);
    chk({tag, " IR_IF"}, IR_IF, ir);
    chk({tag, " PC_IF"}, PC_IF, pcif);
    chk({tag, " valid_IF"}, {31'd0, valid_IF}, {31'd0, v});
    chk({tag, " imem_addr"}, imem_addr, addr);
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, {16'd0, cnt});
  endtask

  task automatic drive(input logic s, input logic h, input logic b, input logic [31:0] t);
    start = s; hasHazard = h; branch_taken = b; branch_target = t;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    #2;
    chk_all("reset", NOP, 32'd0, 1'b0, 32'd0, 16'd0);
    #10 rst = 1'b0;

    //          start hh   br   target          IR_IF           PC_IF           v     addr            cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,          NOP,            32'h0,          0, 32'h0,          16'd0);
    vecs[1]  = mk(0, 0, 0, 32'h0,          32'h8c01_0014,  32'h0,          1, 32'h4,          16'd0);
    vecs[2]  = mk(0, 0, 0, 32'h0,          32'h8c06_0015,  32'h4,          1, 32'h8,          16'd0);
    vecs[3]  = mk(0, 0, 0, 32'h0,          32'h0000_1820,  32'h8,          1, 32'hc,          16'd0);
    vecs[4]  = mk(0, 0, 0, 32'h0,          32'h8c06_0015,  32'hc,          1, 32'h10,         16'd0);
    vecs[5]  = mk(0, 1, 0, 32'h0,          32'h8c06_0015,  32'hc,          1, 32'h10,         16'd1);
    vecs[6]  = mk(0, 1, 0, 32'h0,          32'h8c06_0015,  32'hc,          1, 32'h10,         16'd2);
    vecs[7]  = mk(0, 1, 0, 32'h0,          32'h8c06_0015,  32'hc,          1, 32'h10,         16'd3);
    vecs[8]  = mk(0, 0, 0, 32'h0,          32'ha000_0010,  32'h10,         1, 32'h14,         16'd3);
    vecs[9]  = mk(0, 1, 0, 32'h0,          32'ha000_0010,  32'h10,         1, 32'h14,         16'd4);
    vecs[10] = mk(0, 1, 1, 32'h43,         NOP,            32'h40,         0, 32'h40,         16'd4);
    vecs[11] = mk(0, 1, 0, 32'h0,          32'ha000_0040,  32'h40,         1, 32'h44,         16'd4);
    vecs[12] = mk(0, 0, 1, 32'hffff_ffff,  NOP,            32'hffff_fffc,  0, 32'hffff_fffc,  16'd4);
    vecs[13] = mk(0, 0, 1, 32'h107,        NOP,            32'h104,        0, 32'h104,        16'd4);
    vecs[14] = mk(0, 0, 0, 32'h0,          32'ha000_0104,  32'h104,        1, 32'h108,        16'd4);
    vecs[15] = mk(0, 0, 1, 32'hffff_fffe,  NOP,            32'hffff_fffc,  0, 32'hffff_fffc,  16'd4);
    vecs[16] = mk(0, 0, 0, 32'h0,          32'h5fff_fffc,  32'hffff_fffc,  1, 32'h0,          16'd4);
    vecs[17] = mk(0, 0, 0, 32'h0,          32'h8c01_0014,  32'h0,          1, 32'h4,          16'd4);
    vecs[18] = mk(0, 1, 0, 32'h0,          32'h8c01_0014,  32'h0,          1, 32'h4,          16'd5);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].hh, vecs[i].br, vecs[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].ir, vecs[i].pcif, vecs[i].valid, vecs[i].addr,
              vecs[i].cnt);
    end

    // Asynchronous reset in the middle of a stall, away from any clock edge.
    #1 rst = 1'b1;
    #1;
    chk_all("async_rst", NOP, 32'd0, 1'b0, 32'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    // IDLE ignores both plain cycles and branch redirects.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, (i == 1), 32'h0000_0200);
      @(posedge clk);
      #1;
      chk_all($sformatf("idle%0d", i), NOP, 32'd0, 1'b0, 32'd0, 16'd0);
    end

    // Saturation: start, one fetch, then a stall long enough to reach and pass 16'hffff.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    hasHazard = 1'b1;
    for (int i = 1; i <= 65538; i++) begin
      @(posedge clk);
      #1;
      if (i == 65534) chk("sat fffe", {16'd0, stall_cnt}, 32'h0000_fffe);
      if (i == 65535) chk("sat ffff", {16'd0, stall_cnt}, 32'h0000_ffff);
    end
    chk_all("sat_hold", 32'h8c01_0014, 32'd0, 1'b1, 32'h4, 16'hffff);

    @(negedge clk);
    hasHazard = 1'b0;
    @(posedge clk);
    #1;
    chk_all("sat_release", 32'h8c06_0015, 32'h4, 1'b1, 32'h8, 16'hffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the R/I/J pipeline, directly upstream of the hazard unit.
- Owns the PC and reads the combinational instruction ROM. Registers the fetched word into IR_IF, which feeds the hazard unit.
- Consumes hasHazard to freeze fetch, and consumes branch redirects from the execute stage to squash the wrong-path instruction.
- Inserts the NOP encoding 32'hffff_ffff as a bubble after reset and on every flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'hffff_ffff, bubble encoding driven on IR_IF when no valid instruction is held.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE
- hasHazard  in  1  from the hazard unit; 1 = hold the instruction currently in IR_IF
- branch_taken  in  1  redirect request from execute, valid for one cycle
- branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 0
- imem_addr  out  32  combinational ROM address, always equal to the pc register
- imem_rdata  in  32  combinational ROM data for imem_addr
- IR_IF  out  32  registered fetched instruction
- PC_IF  out  32  address of the instruction in IR_IF
- valid_IF  out  1  1 = IR_IF holds a real instruction; 0 = bubble
- stall_cnt  out  CNT_W  number of cycles spent in STALL, saturating

Behaviour:
- Reset (asynchronous, any cycle, including mid-stall or mid-flush):
  - pc = RESET_PC, IR_IF = NOP_WORD, PC_IF = RESET_PC, valid_IF = 0, stall_cnt = 0, state = IDLE.
- Registered state: pc, IR_IF, PC_IF, valid_IF, stall_cnt, and a 2-bit state register. All update on rising clk only.
- States: IDLE, RUN, STALL, FLUSH.
- IDLE:
  - pc and IR_IF hold; IR_IF stays NOP_WORD.
  - start=1 -> RUN. The first fetch captures on the following edge.
- RUN, with no branch and hasHazard=0:
  - IR_IF <= imem_rdata, PC_IF <= pc, valid_IF <= 1, pc <= pc+4.
  - pc+4 wraps modulo 2^32.
  - Fetch latency is 1 cycle: the instruction at address A appears on IR_IF one edge after pc=A.
- RUN with hasHazard=1 (no branch):
  - pc, IR_IF, PC_IF and valid_IF hold; stall_cnt increments; go to STALL.
- STALL:
  - While hasHazard=1: hold everything and increment stall_cnt every cycle.
  - When hasHazard=0: perform a normal RUN fetch on that same edge and return to RUN. There is no extra bubble cycle.
- Saturation: stall_cnt stops at 2^CNT_W-1 and never wraps.
- Branch (branch_taken=1 in RUN or STALL):
  - Highest priority; overrides hasHazard on the same edge.
  - pc <= {branch_target[31:2], 2'b00}, IR_IF <= NOP_WORD, valid_IF <= 0, PC_IF <= that target. Go to FLUSH.
  - stall_cnt does not increment on the branch edge.
- FLUSH:
  - Lasts one cycle; the wrong-path slot is already squashed.
  - Next edge performs a normal fetch from the target. hasHazard is ignored in FLUSH because a NOP cannot create a hazard.
  - Goes to RUN; a branch_taken in FLUSH re-redirects and stays in FLUSH.
- branch_taken in IDLE is ignored.
- hasHazard is combinational from the hazard unit, which observes IR_IF. IF keeps IR_IF stable for the whole stall so the hazard unit re-evaluates the same word each cycle.
- imem_addr is pure combinational output of pc. No other output has a combinational path from any input.

Test Plan:
- Reset then start with ROM[0]=32'h8c01_0014, ROM[4]=32'h8c06_0015 -> edge 1 after start: IR_IF=8c01_0014, PC_IF=0, valid_IF=1; edge 2: IR_IF=8c06_0015, PC_IF=4; imem_addr=8.
- ROM[8]=32'h0000_1820, ROM[12]=32'h8c06_0015; hold hasHazard=1 for 3 cycles while IR_IF=8c06_0015 (PC_IF=12) -> IR_IF, PC_IF=12 and pc=16 are frozen for 3 edges; stall_cnt=3; first edge after release loads ROM[16].
- branch_taken=1, branch_target=32'h0000_0043 while hasHazard=1 -> next edge: pc=32'h40, IR_IF=ffff_ffff, valid_IF=0, stall_cnt unchanged; following edge: IR_IF=ROM[0x40], PC_IF=0x40.
- Assert rst asynchronously mid-STALL with stall_cnt=5 -> all outputs immediately at reset values (IR_IF=ffff_ffff, pc=0, stall_cnt=0, state IDLE); no fetch until start.
- Force stall_cnt to 16'hfffe and hold hasHazard=1 for 4 cycles -> stall_cnt=16'hffff and stays there.
- Load pc=32'hffff_fffc via a branch and run 2 fetches -> PC_IF=ffff_fffc, then pc wraps and the next PC_IF=0.
